icb_scheduler: RTL

Frame-level work dispatcher for the iteration compute block (ICB) array. It assigns each of NUM ICBs one pixel row of the current section. It hands out columns 0..WIDTH-1 one at a time and pulses `start` to launch each pixel. Each write-back handshake (`shake`) from the memory controller advances that ICB to its next column, and the block steps `sectnum` through all sections of the frame.

---
 rtl/icb_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icb_scheduler.sv
// Frame-level work dispatcher: hands out pixel columns to NUM ICBs and steps sectnum through the frame.
// Optional launch-pause support is enabled by defining ICB_SCHED_PAUSE_EN.
module icb_scheduler #(
    parameter int NUM      = 30,
    parameter int WIDTH    = 640,
    parameter int SECTIONS = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic [NUM-1:0]    shake,
`ifdef ICB_SCHED_PAUSE_EN
    input  logic              pause,
`endif
    output logic [NUM-1:0]    start,
    output logic [NUM*10-1:0] bitNum,
    output logic [3:0]        sectnum,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADVANCE
    } state_t;

    localparam logic [9:0] LAST_COL  = 10'(WIDTH - 1);
    localparam logic [3:0] LAST_SECT = 4'(SECTIONS - 1);

    state_t         state_q, state_d;
    logic [9:0]     col_q [NUM];
    logic [9:0]     col_d [NUM];
    logic [NUM-1:0] fin_q, fin_d;
    logic [3:0]     sect_q, sect_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [NUM-1:0] start_q, start_d;
    logic [NUM-1:0] launch;
`ifdef ICB_SCHED_PAUSE_EN
    logic [NUM-1:0] pending_q, pending_d;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        fin_d   = fin_q;
        sect_d  = sect_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        launch  = '0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = RUN;
                    for (int i = 0; i < NUM; i++) col_d[i] = '0;
                    fin_d  = '0;
                    sect_d = '0;
                    busy_d = 1'b1;
                    launch = '1;
                end
            end
            RUN: begin
                // Each ICB advances independently; the last column only marks it finished.
                for (int i = 0; i < NUM; i++) begin
                    if (shake[i] && !fin_q[i]) begin
                        if (col_q[i] == LAST_COL) begin
                            fin_d[i] = 1'b1;
                        end else begin
                            col_d[i]  = col_q[i] + 10'd1;
                            launch[i] = 1'b1;
                        end
                    end
                end
                if (&fin_q) begin
`ifdef ICB_SCHED_PAUSE_EN
                    if (pending_q == '0) state_d = ADVANCE;
`else
                    state_d = ADVANCE;
`endif
                end
            end
            ADVANCE: begin
                if (sect_q < LAST_SECT) begin
                    state_d = RUN;
                    sect_d  = sect_q + 4'd1;
                    for (int i = 0; i < NUM; i++) col_d[i] = '0;
                    fin_d   = '0;
                    launch  = '1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ICB_SCHED_PAUSE_EN
        // Launches raised while paused are parked and released together on the first unpaused cycle.
        if (pause) begin
            start_d   = '0;
            pending_d = pending_q | launch;
        end else begin
            start_d   = pending_q | launch;
            pending_d = '0;
        end
`else
        start_d = launch;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM; i++) col_q[i] <= '0;
            fin_q   <= '0;
            sect_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= '0;
`ifdef ICB_SCHED_PAUSE_EN
            pending_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            fin_q   <= fin_d;
            sect_q  <= sect_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
`ifdef ICB_SCHED_PAUSE_EN
            pending_q <= pending_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_bitnum
        assign bitNum[g*10 +: 10] = col_q[g];
    end

    assign start      = start_q;
    assign sectnum    = sect_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
